// File: rtl/cpu_step_controller_if.sv
// Board-side signal bundle for cpu_step_controller.
// master: the board/CPU side driving buttons, PC feedback and breakpoint setup.
// slave : the step controller itself.
interface cpu_step_controller_if;
    logic        btn_step;
    logic        sw_run;
    logic [31:0] pc_fe;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        cpu_clk;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cycle_count;

    modport master (
        output btn_step, sw_run, pc_fe, bp_addr, bp_en,
        input  cpu_clk, halted, bp_hit, cycle_count
    );

    modport slave (
        input  btn_step, sw_run, pc_fe, bp_addr, bp_en,
        output cpu_clk, halted, bp_hit, cycle_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: drives the CPU clock from the board clock, either as a
// free-running divided clock (run switch) or as single pulses (step button).
// Both buttons are synchronized and debounced. Halts when the fetch PC fed back
// from the CPU matches the breakpoint address.
// Optional feature macro: STEP_BREAKPOINT_EN (breakpoint comparator and bp_hit).
module cpu_step_controller #(
    parameter int DIV      = 4,
    parameter int DEBOUNCE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_step_controller_if.slave  bus
);

    localparam int PW = $clog2(DIV) + 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0] PH_ZERO = PW'(0);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_ZERO = DW'(0);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Index 0: step button, index 1: run switch.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync_r;
    logic [1:0]    db_r;
    logic [1:0]    db_q_r;
    logic [DW-1:0] db_cnt_r [2];

    state_t        state_r;
    state_t        state_nx;
    logic [PW-1:0] phase_r;
    logic [PW-1:0] phase_nx;

    logic          cpu_clk_r;
    logic          halted_r;
    logic          bp_hit_r;
    logic [31:0]   cycle_count_r;

    logic          cpu_clk_nx;
    logic          halted_nx;
    logic          bp_hit_nx;
    logic [31:0]   cycle_count_nx;

    logic          step_req_s;
    logic          run_s;
    logic          run_fall_s;
    logic          phase_done_s;
    logic          bp_match_s;
    logic          bp_set_s;
    logic          bp_clr_step_s;
    logic          count_inc_s;

    // Address comparator used on the last LOW cycle, once pc_fe has settled.
    function automatic logic bp_compare(input logic en, input logic [31:0] pc,
                                        input logic [31:0] addr);
        return en && (pc == addr);
    endfunction

    assign raw_s        = {bus.sw_run, bus.btn_step};
    assign step_req_s   = db_r[0] & ~db_q_r[0];
    assign run_s        = db_r[1];
    assign run_fall_s   = ~db_r[1] & db_q_r[1];
    assign phase_done_s = (phase_r == PH_LAST);

`ifdef STEP_BREAKPOINT_EN
    assign bp_match_s = bp_compare(bus.bp_en, bus.pc_fe, bus.bp_addr);
`else
    logic unused_bp_s;
    assign unused_bp_s = bp_compare(bus.bp_en, bus.pc_fe, bus.bp_addr);
    assign bp_match_s  = 1'b0;
`endif

    // Two-flop synchronizers followed by per-input stability-counter debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync_r  <= 2'b00;
            db_r    <= 2'b00;
            db_q_r  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            sync1_r <= raw_s;
            sync_r  <= sync1_r;
            db_q_r  <= db_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] != db_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        db_r[i]     <= sync_r[i];
                        db_cnt_r[i] <= DB_ZERO;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                    end
                end else begin
                    db_cnt_r[i] <= DB_ZERO;
                end
            end
        end
    end

    // FSM state and phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= PH_ZERO;
        end else begin
            state_r <= state_nx;
            phase_r <= phase_nx;
        end
    end

    // Next-state logic: IDLE waits for run/step, HIGH and LOW each last DIV cycles.
    always_comb begin
        state_nx      = state_r;
        phase_nx      = phase_r;
        bp_set_s      = 1'b0;
        bp_clr_step_s = 1'b0;
        count_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_nx = PH_ZERO;
                if (run_s && !bp_hit_r) begin
                    state_nx    = ST_HIGH;
                    count_inc_s = 1'b1;
                end else if (step_req_s) begin
                    state_nx      = ST_HIGH;
                    count_inc_s   = 1'b1;
                    bp_clr_step_s = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (phase_done_s) begin
                    state_nx = ST_LOW;
                    phase_nx = PH_ZERO;
                end else begin
                    phase_nx = phase_r + PH_ONE;
                end
            end
            ST_LOW: begin
                if (phase_done_s) begin
                    phase_nx = PH_ZERO;
                    if (bp_match_s) begin
                        state_nx = ST_IDLE;
                        bp_set_s = 1'b1;
                    end else if (run_s) begin
                        state_nx    = ST_HIGH;
                        count_inc_s = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    phase_nx = phase_r + PH_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                phase_nx = PH_ZERO;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state.
    always_comb begin
        cpu_clk_nx     = (state_nx == ST_HIGH);
        halted_nx      = (state_nx == ST_IDLE);
        cycle_count_nx = cycle_count_r;
        if (count_inc_s) begin
            cycle_count_nx = cycle_count_r + 32'd1;
        end else begin
            cycle_count_nx = cycle_count_r;
        end
`ifdef STEP_BREAKPOINT_EN
        if (bp_set_s) begin
            bp_hit_nx = 1'b1;
        end else if (bp_clr_step_s || run_fall_s) begin
            bp_hit_nx = 1'b0;
        end else begin
            bp_hit_nx = bp_hit_r;
        end
`else
        bp_hit_nx = 1'b0;
`endif
    end

    // Output registers: cpu_clk is a flop so the CPU never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_clk_r     <= 1'b0;
            halted_r      <= 1'b1;
            bp_hit_r      <= 1'b0;
            cycle_count_r <= 32'd0;
        end else begin
            cpu_clk_r     <= cpu_clk_nx;
            halted_r      <= halted_nx;
            bp_hit_r      <= bp_hit_nx;
            cycle_count_r <= cycle_count_nx;
        end
    end

    assign bus.cpu_clk     = cpu_clk_r;
    assign bus.halted      = halted_r;
    assign bus.bp_hit      = bp_hit_r;
    assign bus.cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed testbench for cpu_step_controller with DIV=2, DEBOUNCE=4.
// Breakpoint expectations depend on STEP_BREAKPOINT_EN.
module tb_cpu_step_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int fails   = 0;
    int rises   = 0;
    int pc_base = 0;

    cpu_step_controller_if bus();

    cpu_step_controller #(.DIV(2), .DEBOUNCE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // CPU model: fetch PC advances by 4 on every cpu_clk rise.
    always @(posedge bus.cpu_clk) rises++;
    assign bus.pc_fe = 32'((rises - pc_base) * 4);

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.btn_step = 1'b0;
        bus.sw_run   = 1'b0;
        tick(2);
        rst_n   = 1'b1;
        pc_base = rises;
    endtask

    initial begin
        bus.btn_step = 1'b0;
        bus.sw_run   = 1'b0;
        bus.bp_addr  = 32'h0;
        bus.bp_en    = 1'b0;
        tick(2);
        check("rst_cpu_clk", {31'd0, bus.cpu_clk}, 32'd0);
        check("rst_halted",  {31'd0, bus.halted},  32'd1);
        check("rst_bp_hit",  {31'd0, bus.bp_hit},  32'd0);
        check("rst_count",   bus.cycle_count,      32'd0);

        // Single step: rise after edge 7, high for 2 cycles.
        do_reset();
        bus.btn_step = 1'b1;
        tick(6);
        check("step_e6_low",   {31'd0, bus.cpu_clk}, 32'd0);
        tick(1);
        check("step_e7_high",  {31'd0, bus.cpu_clk}, 32'd1);
        check("step_e7_halt",  {31'd0, bus.halted},  32'd0);
        check("step_e7_count", bus.cycle_count,      32'd1);
        tick(1);
        check("step_e8_high",  {31'd0, bus.cpu_clk}, 32'd1);
        tick(1);
        check("step_e9_low",   {31'd0, bus.cpu_clk}, 32'd0);
        tick(11);
        bus.btn_step = 1'b0;
        tick(10);
        check("step_count",    bus.cycle_count,      32'd1);
        check("step_halted",   {31'd0, bus.halted},  32'd1);
        check("step_cpu_clk",  {31'd0, bus.cpu_clk}, 32'd0);

        // Bounce rejection: 2-cycle toggles never survive the debouncer.
        do_reset();
        pc_base = rises;
        for (int i = 0; i < 6; i++) begin
            bus.btn_step = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(2);
        end
        bus.btn_step = 1'b0;
        tick(20);
        check("bounce_rises", 32'(rises - pc_base), 32'd0);
        check("bounce_count", bus.cycle_count,      32'd0);

        // Free run: period 4, first rise after edge 7.
        do_reset();
        bus.sw_run = 1'b1;
        tick(6);
        check("run_e6_low", {31'd0, bus.cpu_clk}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("run_rise",  {31'd0, bus.cpu_clk}, 32'd1);
            check("run_count", bus.cycle_count,      32'(k + 1));
            tick(1);
            check("run_high2", {31'd0, bus.cpu_clk}, 32'd1);
            tick(1);
            check("run_low1",  {31'd0, bus.cpu_clk}, 32'd0);
            tick(1);
            check("run_low2",  {31'd0, bus.cpu_clk}, 32'd0);
        end
        // Drop run before edge 23: rises at 23 and 27 still happen, idle after 31.
        bus.sw_run = 1'b0;
        tick(30);
        check("stop_count",   bus.cycle_count,      32'd6);
        check("stop_halted",  {31'd0, bus.halted},  32'd1);
        check("stop_cpu_clk", {31'd0, bus.cpu_clk}, 32'd0);
        tick(10);
        check("stop_hold",    bus.cycle_count,      32'd6);

        // Reset mid-pulse: cpu_clk drops without a clk edge.
        do_reset();
        bus.btn_step = 1'b1;
        tick(7);
        check("mid_high",  {31'd0, bus.cpu_clk}, 32'd1);
        check("mid_count", bus.cycle_count,      32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cpu_clk", {31'd0, bus.cpu_clk}, 32'd0);
        check("mid_rst_count",   bus.cycle_count,      32'd0);
        check("mid_rst_halted",  {31'd0, bus.halted},  32'd1);
        bus.btn_step = 1'b0;
        tick(2);

        // Breakpoint at 0x10 while running.
        do_reset();
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h10;
        bus.sw_run  = 1'b1;
        tick(46);
`ifdef STEP_BREAKPOINT_EN
        check("bp_count",  bus.cycle_count,      32'd4);
        check("bp_hit",    {31'd0, bus.bp_hit},  32'd1);
        check("bp_halted", {31'd0, bus.halted},  32'd1);
        check("bp_pc",     bus.pc_fe,            32'h10);
        bus.sw_run = 1'b0;
        tick(10);
        check("bp_runfall_clr", {31'd0, bus.bp_hit}, 32'd0);
        check("bp_runfall_cnt", bus.cycle_count,     32'd4);
        // Step onto a new breakpoint at 0x14.
        bus.bp_addr  = 32'h14;
        bus.btn_step = 1'b1;
        tick(20);
        bus.btn_step = 1'b0;
        tick(20);
        check("bp_step_hit",   {31'd0, bus.bp_hit}, 32'd1);
        check("bp_step_count", bus.cycle_count,     32'd5);
        check("bp_step_halt",  {31'd0, bus.halted}, 32'd1);
        // A further step clears the sticky flag and issues exactly one pulse.
        bus.btn_step = 1'b1;
        tick(20);
        bus.btn_step = 1'b0;
        tick(20);
        check("bp_clr_hit",   {31'd0, bus.bp_hit}, 32'd0);
        check("bp_clr_count", bus.cycle_count,     32'd6);
        check("bp_clr_halt",  {31'd0, bus.halted}, 32'd1);
`else
        check("nobp_count",  bus.cycle_count,     32'd10);
        check("nobp_hit",    {31'd0, bus.bp_hit}, 32'd0);
        check("nobp_halted", {31'd0, bus.halted}, 32'd0);
        bus.sw_run = 1'b0;
        tick(20);
        check("nobp_stop_hit", {31'd0, bus.bp_hit}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/cpu_step_controller.md
# cpu_step_controller

Board-level clock controller that sits directly upstream of the pipelined CPU and drives its only input, `clk`. It takes the fast board clock, debounces a step button and a run switch, and produces either a free-running divided CPU clock or single pulses. It compares the fetch-stage PC fed back from the CPU against an optional breakpoint address and halts on a match.

## Interface
Parameters:
- `DIV`, default 4: length of the cpu_clk high phase, and of its low phase, in `clk` cycles; must be ≥1.
- `DEBOUNCE`, default 16: number of consecutive stable `clk` cycles before a debounced input changes; must be ≥2.

Ports:
- `clk`  in  1  board clock; sole clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_step`  in  1  raw step button, asynchronous, active-high.
- `sw_run`  in  1  raw run switch, asynchronous, active-high.
- `pc_fe`  in  32  fetch-stage PC fed back from the CPU debug output.
- `bp_addr`  in  32  breakpoint address.
- `bp_en`  in  1  breakpoint enable.
- `cpu_clk`  out  1  registered clock to the CPU; its rising edge is the CPU's active edge.
- `halted`  out  1  1 while the FSM is in IDLE.
- `bp_hit`  out  1  sticky breakpoint flag.
- `cycle_count`  out  32  number of cpu_clk rising edges since reset.

## Operation
- **Synchronizers.** Each of `btn_step` and `sw_run` passes through a 2-flop synchronizer (`s`).
- **Debounce, per input.**
  - A counter increments while `s != db` and clears while `s == db`.
  - When `s != db` has held for DEBOUNCE consecutive edges, `db <= s` and the counter clears.
- **Step request.** `step_req = db_step & ~db_step_q`, a one-cycle pulse on the rising edge of the debounced button.
- **FSM.** Three states, with a phase counter of width clog2(DIV)+1.
  - IDLE (`cpu_clk`=0):
    - If `db_run` and not `bp_hit`, go to HIGH.
    - Otherwise, if `step_req`, clear `bp_hit` and go to HIGH.
  - HIGH (`cpu_clk`=1): after DIV cycles, go to LOW.
  - LOW (`cpu_clk`=0): after DIV cycles:
    - If the breakpoint matches, set `bp_hit` and go to IDLE.
    - Else if `db_run`, go to HIGH.
    - Else go to IDLE.
- **Breakpoint match.** `bp_en && pc_fe == bp_addr`, evaluated only on the final LOW cycle, when `pc_fe` has settled after the preceding rising edge.
- **Clearing `bp_hit`.** It clears on `step_req` in IDLE, or on a falling edge of `db_run`.
- **Cycle count.** `cycle_count` increments on every IDLE→HIGH and LOW→HIGH transition. It wraps from 0xFFFFFFFF to 0.
- **Ignored step requests.** `step_req` outside IDLE is dropped and never queued; this covers step presses during run and during an in-progress step.
- **Run switch going low.** A `db_run` fall mid-pulse lets the current HIGH/LOW phase complete, then the FSM goes to IDLE.

## Timing
Reset values (asynchronous; effective while `rst_n`=0):

| Signal | Value |
|---|---|
| state | IDLE |
| `cpu_clk` | 0 |
| `halted` | 1 |
| `bp_hit` | 0 |
| `cycle_count` | 0 |
| sync, debounce and phase registers | 0 |

- **Reset mid-pulse.** `cpu_clk` falls immediately, without waiting for a `clk` edge.
- **Step latency.** For a clean raw rise before `clk` edge 1:
  - `s` rises after edge 2.
  - `db` rises after edge 2+DEBOUNCE.
  - `cpu_clk` rises after edge 3+DEBOUNCE.
- **Run waveform.** Period is exactly 2·DIV `clk` cycles at 50% duty. There is no extra cycle between LOW and the next HIGH.
- **Glitch-free output.** `cpu_clk` is a flop output; there are no combinational paths from inputs to `cpu_clk`.
- **Simultaneous events.** If `step_req` and `db_run` are both true in IDLE, exactly one transition to HIGH occurs.

## Configuration
- **`STEP_BREAKPOINT_EN` defined:** the breakpoint comparator and `bp_hit` logic are present as described above.
- **`STEP_BREAKPOINT_EN` undefined:**
  - The comparator is removed and `bp_hit` is tied to 0.
  - `bp_addr` and `bp_en` are ignored.
  - LOW→IDLE occurs only when `db_run` is 0.

## Test plan
All scenarios use DIV=2 and DEBOUNCE=4.
- **Single step.** Reset, then hold `btn_step` for 20 cycles → exactly one `cpu_clk` pulse, rising after edge 7 and high for 2 cycles. `cycle_count`=1 and `halted` returns to 1.
- **Bounce rejection.** `btn_step` toggles every 2 cycles for 12 cycles, then stays 0 → no pulse and `cycle_count`=0.
- **Free run.**
  - `sw_run`=1 → a square wave with period 4 starts after the debounce latency, and `cycle_count` increments every 4 cycles.
  - Drop `sw_run` → the current pulse completes and `cpu_clk` stays 0.
- **Breakpoint halt and resume** (macro defined).
  - Setup: `bp_en`=1, `bp_addr`=0x10; a model advances `pc_fe` by 4 per `cpu_clk` rise, starting from 0.
  - Run → halts after 4 pulses with `bp_hit`=1, `halted`=1, `cycle_count`=4.
  - One step press → one pulse, `bp_hit`=0, `cycle_count`=5.
- **Reset mid-pulse.** Assert `rst_n`=0 during HIGH → `cpu_clk`=0 without waiting for a `clk` edge, and `cycle_count`=0.
- **Macro undefined.** Same stimulus as the breakpoint scenario → no halt at 0x10, `bp_hit` stays 0, and the count keeps rising.
